tggl_md_drv: RTL and testbench

- Initiator-side driver for the mode-toggle pushbutton line.
- Drives the active-low button pin so the downstream mode selector steps to a requested 2-bit cycle value.
- Keeps a shadow copy of the selector's cycle counter and issues the minimum number of press/release pulses, stepping forward modulo 4.
- Sits in the stimulus/control layer. It replaces a physical pushbutton for automated mode selection and bench bring-up.

---
 rtl/tggl_md_drv.sv | 143 ++++++++++++++
 tb/tb_tggl_md_drv.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/tggl_md_drv.sv
// Mode-toggle pushbutton driver: pulses the active-low pin until the tracked selector cycle reaches the target.
// Optional abort input/aborted pulse enabled with `define TGGL_MD_DRV_ABORT_EN.
module tggl_md_drv #(
  parameter int PRESS_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req,
  input  logic [1:0] i_target,
`ifdef TGGL_MD_DRV_ABORT_EN
  input  logic       i_abort,
  output logic       o_aborted,
`endif
  output logic       o_tggl_n,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_shadow_cycle
);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]         r_rem, w_rem_nxt;
  logic [1:0]         r_tgt, w_tgt_nxt;
  logic [1:0]         r_shadow;
  logic [1:0]         w_diff;
  logic               w_abt;
  logic               w_abt_ret;
  logic               r_tggl_n, r_busy, r_done;

`ifdef TGGL_MD_DRV_ABORT_EN
  logic               r_abt_pend;
  logic               r_abt_ret;
  logic               r_aborted;

  // An abort seen anywhere in PRESS/GAP is remembered until the current gap ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abt_pend <= 1'b0;
      r_abt_ret  <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      if (r_state == S_PRESS || r_state == S_GAP)
        r_abt_pend <= r_abt_pend | i_abort;
      else
        r_abt_pend <= 1'b0;
      r_abt_ret <= w_abt_ret;
      r_aborted <= r_abt_ret;
    end
  end

  assign w_abt     = r_abt_pend | i_abort;
  assign o_aborted = r_aborted;
`else
  assign w_abt = 1'b0;
`endif

  assign w_diff = i_target - r_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= 2'd0;
      r_tgt   <= 2'b10;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rem   <= w_rem_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_tgt_nxt   = r_tgt;
    w_abt_ret   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_tgt_nxt   = i_target;
          w_rem_nxt   = w_diff;
          w_cnt_nxt   = '0;
          w_state_nxt = (w_diff != 2'd0) ? S_PRESS : S_DONE;
        end
      end
      S_PRESS: begin
        if (r_cnt == CNT_W'(PRESS_CYC - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
          w_cnt_nxt = '0;
          w_rem_nxt = r_rem - 2'd1;
          if (w_abt) begin
            w_rem_nxt   = 2'd0;
            w_abt_ret   = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (r_rem == 2'd1) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_PRESS;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pin and status are registered from the current state, so they trail it by one clock
  // and can never glitch. The shadow steps on the first gap cycle, in line with the pin release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tggl_n <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_shadow <= 2'b10;
    end else begin
      r_tggl_n <= (r_state != S_PRESS);
      r_busy   <= (r_state == S_PRESS) || (r_state == S_GAP);
      r_done   <= (r_state == S_DONE) && (r_shadow == r_tgt);
      if (r_state == S_GAP && r_cnt == '0)
        r_shadow <= r_shadow + 2'd1;
    end
  end

  assign o_tggl_n       = r_tggl_n;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_shadow_cycle = r_shadow;

endmodule

// File: tb/tb_tggl_md_drv.sv
// Directed bench for tggl_md_drv with a small model of the receiving mode selector.
module tb_tggl_md_drv;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [1:0] target;
  logic       tggl_n;
  logic       busy;
  logic       done;
  logic [1:0] shadow_cycle;
`ifdef TGGL_MD_DRV_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks   = 0;
  int failures = 0;

  tggl_md_drv #(.PRESS_CYC(4), .GAP_CYC(4), .CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req          (req),
    .i_target       (target),
`ifdef TGGL_MD_DRV_ABORT_EN
    .i_abort        (abort),
    .o_aborted      (aborted),
`endif
    .o_tggl_n       (tggl_n),
    .o_busy         (busy),
    .o_done         (done),
    .o_shadow_cycle (shadow_cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selector model: 2-flop synchronizer plus edge flop, steps on each pin release.
  logic [2:0] sel_sy;
  logic [1:0] sel_cycle;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_sy    <= 3'b111;
      sel_cycle <= 2'b10;
    end else begin
      sel_sy <= {sel_sy[1:0], tggl_n};
      if (sel_sy[1] && !sel_sy[2])
        sel_cycle <= sel_cycle + 2'd1;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and check every cycle up to done; optionally pulse a competing req mid-run.
  task automatic run_req(input logic [1:0] tgt, input int n, input logic [1:0] start,
                         input int pulse_at);
    logic [1:0] se;
    int         p;
    @(negedge clk);
    req    = 1'b1;
    target = tgt;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("j0_pin", {7'd0, tggl_n}, 8'd1);
    chk("j0_busy", {7'd0, busy}, 8'd0);
    chk("j0_done", {7'd0, done}, 8'd0);
    for (int j = 1; j <= 8 * n + 1; j++) begin
      @(negedge clk);
      if (j == pulse_at + 1) begin
        req    = 1'b0;
        target = tgt;
      end
      if (j == pulse_at) begin
        req    = 1'b1;
        target = 2'b11;
      end
      p = 0;
      for (int i = 0; i < n; i++)
        if (j >= 5 + 8 * i) p++;
      se = start + 2'(p);
      chk("pin", {7'd0, tggl_n}, ((j <= 8 * n) && (((j - 1) % 8) < 4)) ? 8'd0 : 8'd1);
      chk("busy", {7'd0, busy}, (j <= 8 * n) ? 8'd1 : 8'd0);
      chk("done", {7'd0, done}, (j == 8 * n + 1) ? 8'd1 : 8'd0);
      chk("shadow", {6'd0, shadow_cycle}, {6'd0, se});
    end
    req = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("post_done", {7'd0, done}, 8'd0);
      chk("post_pin", {7'd0, tggl_n}, 8'd1);
    end
    chk("sel_model", {6'd0, sel_cycle}, {6'd0, tgt});
  endtask

  initial begin
    rst_n  = 1'b1;
    req    = 1'b0;
    target = 2'b00;
`ifdef TGGL_MD_DRV_ABORT_EN
    abort  = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pin", {7'd0, tggl_n}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_shadow", {6'd0, shadow_cycle}, 8'h02);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_req(2'b10, 0, 2'b10, -5);
    run_req(2'b00, 2, 2'b10, -5);
    run_req(2'b10, 2, 2'b00, -5);
    run_req(2'b01, 3, 2'b10, 10);

    // Reset in the middle of the second press, from shadow 01 towards 00.
    @(negedge clk);
    req    = 1'b1;
    target = 2'b00;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_pin", {7'd0, tggl_n}, 8'd0);
    chk("pre_rst_shadow", {6'd0, shadow_cycle}, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pin", {7'd0, tggl_n}, 8'd1);
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_shadow", {6'd0, shadow_cycle}, 8'h02);
    chk("arst_sel", {6'd0, sel_cycle}, 8'h02);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_pin", {7'd0, tggl_n}, 8'd1);

`ifdef TGGL_MD_DRV_ABORT_EN
    @(negedge clk);
    req    = 1'b1;
    target = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      abort = (j == 2);
      chk("ab_pin", {7'd0, tggl_n}, (j <= 4) ? 8'd0 : 8'd1);
      chk("ab_busy", {7'd0, busy}, (j <= 8) ? 8'd1 : 8'd0);
      chk("ab_done", {7'd0, done}, 8'd0);
      chk("ab_aborted", {7'd0, aborted}, (j == 9) ? 8'd1 : 8'd0);
    end
    chk("ab_shadow", {6'd0, shadow_cycle}, 8'h03);
    chk("ab_sel", {6'd0, sel_cycle}, 8'h03);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
